// File: rtl/mux_nx1_reg.sv
// Registered N:1 channel multiplexer with a valid/ready handshake on both sides.
// Illegal selects are consumed, raise a sticky flag and bump a saturating error counter.
module mux_nx1_reg #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  input  logic               err_clr,
  output logic               sel_err,
  output logic [7:0]         err_count
);

  // One extra bit so the channel count itself is representable when N is a power of two.
  localparam logic [SELW:0] N_LIM = (SELW+1)'(N);

  logic             sel_legal;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err_next;
  logic [7:0]       err_count_next;

  assign sel_legal = ({1'b0, sel} < N_LIM);
  assign in_ready  = (!out_valid || out_ready) && !flush && !reset;
  assign accept    = in_valid && in_ready;

  // NOTE: every always_comb output gets a default before any conditional update,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) sel_data |= in_bus[i*WIDTH +: WIDTH];
    end
  end

  // Clear first, then let a same-cycle illegal accept count on top of the cleared value.
  always_comb begin
    sel_err_next   = sel_err;
    err_count_next = err_count;
    if (err_clr) begin
      sel_err_next   = 1'b0;
      err_count_next = 8'd0;
    end
    if (accept && !sel_legal) begin
      sel_err_next = 1'b1;
      if (err_count_next != 8'hFF) err_count_next = err_count_next + 8'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: out_data is a single register, not a memory, so it is cleared on reset
  // to give a defined value downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      sel_err   <= sel_err_next;
      err_count <= err_count_next;
      if (accept) begin
        if (sel_legal) begin
          out_data  <= sel_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Directed bench for mux_nx1_reg: an N=4 instance checked through a scoreboard queue
// and an N=3 instance exercising illegal selects, saturation, flush and reset.
module tb_mux_nx1_reg;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // N=4 instance
  logic            a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic            a_flush, a_err_clr, a_sel_err;
  logic [1:0]      a_sel;
  logic [4*W-1:0]  a_in_bus;
  logic [W-1:0]    a_out_data;
  logic [7:0]      a_err_count;

  // N=3 instance
  logic            b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic            b_flush, b_err_clr, b_sel_err;
  logic [1:0]      b_sel;
  logic [3*W-1:0]  b_in_bus;
  logic [W-1:0]    b_out_data;
  logic [7:0]      b_err_count;

  logic [W-1:0] sb[$];

  mux_nx1_reg #(.WIDTH(W), .N(4)) dut_a (
    .clk(clk), .reset(a_reset), .in_bus(a_in_bus), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .flush(a_flush),
    .err_clr(a_err_clr), .sel_err(a_sel_err), .err_count(a_err_count)
  );

  mux_nx1_reg #(.WIDTH(W), .N(3)) dut_b (
    .clk(clk), .reset(b_reset), .in_bus(b_in_bus), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .flush(b_flush),
    .err_clr(b_err_clr), .sel_err(b_sel_err), .err_count(b_err_count)
  );

  function automatic logic [W-1:0] chan_val(input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 17);
    return {8{b}};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on instance A: drive, check in_ready, score the transfer, then check
  // that out_valid/out_data match the item the scoreboard says is held.
  task automatic a_step(input logic v, input logic [1:0] s, input logic ordy,
                        input logic fl, input logic exp_rdy);
    logic [W-1:0] exp_d;
    a_in_valid = v; a_sel = s; a_out_ready = ordy; a_flush = fl;
    #1;
    check("a_in_ready", 64'(a_in_ready), 64'(exp_rdy));
    if (a_out_valid && (ordy || fl)) begin
      if (sb.size() == 0) begin
        check("a_spurious_out", 64'(a_out_valid), 64'(0));
      end else begin
        exp_d = sb.pop_front();
        if (!fl) check("a_transfer_data", a_out_data, exp_d);
      end
    end
    if (v && exp_rdy) sb.push_back(chan_val(int'(s)));
    @(posedge clk); #1;
    check("a_out_valid", 64'(a_out_valid), 64'(sb.size() > 0));
    if (sb.size() > 0) check("a_out_data_head", a_out_data, sb[0]);
  endtask

  task automatic b_step(input logic v, input logic [1:0] s, input logic ordy,
                        input logic fl, input logic clr);
    b_in_valid = v; b_sel = s; b_out_ready = ordy; b_flush = fl; b_err_clr = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b0; a_sel = '0; a_out_ready = 1'b0;
    a_flush = 1'b0; a_err_clr = 1'b0;
    a_in_bus = {chan_val(3), chan_val(2), chan_val(1), chan_val(0)};
    b_reset = 1'b1; b_in_valid = 1'b0; b_sel = '0; b_out_ready = 1'b0;
    b_flush = 1'b0; b_err_clr = 1'b0;
    b_in_bus = {chan_val(2), chan_val(1), chan_val(0)};

    #1;
    check("a_in_ready_in_reset", 64'(a_in_ready), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("a_rst_out_data", a_out_data, 64'(0));
    check("a_rst_out_valid", 64'(a_out_valid), 64'(0));
    check("a_rst_sel_err", 64'(a_sel_err), 64'(0));
    check("a_rst_err_count", 64'(a_err_count), 64'(0));
    a_reset = 1'b0; b_reset = 1'b0;
    #1;
    check("a_in_ready_after_reset", 64'(a_in_ready), 64'(1));
    check("b_in_ready_after_reset", 64'(b_in_ready), 64'(1));

    // Single select of channel 2, one-cycle latency.
    a_step(1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    check("a_sel2_data", a_out_data, 64'h3333_3333_3333_3333);

    // Back-to-back sel 0..3 with no bubble, then drain.
    for (int i = 0; i < 4; i++) a_step(1'b1, 2'(i), 1'b1, 1'b0, 1'b1);
    check("a_b2b_last", a_out_data, 64'h4444_4444_4444_4444);
    a_step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure: held item, in_ready low, release then next item.
    a_step(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    a_step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    a_step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    check("a_stall_held", a_out_data, 64'h2222_2222_2222_2222);
    a_step(1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
    check("a_after_stall", a_out_data, 64'h4444_4444_4444_4444);
    a_step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

    // Flush drops the held item and blocks the accept; out_data is kept.
    a_step(1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    a_step(1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    check("a_flush_data_kept", a_out_data, 64'h1111_1111_1111_1111);

    // Reset while an item is held under backpressure.
    a_step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    a_reset = 1'b1; a_in_valid = 1'b1; a_sel = 2'd3; a_err_clr = 1'b1;
    #1;
    check("a_in_ready_midreset", 64'(a_in_ready), 64'(0));
    @(posedge clk); #1;
    sb.delete();
    check("a_midreset_data", a_out_data, 64'(0));
    check("a_midreset_valid", 64'(a_out_valid), 64'(0));
    check("a_sel_err_pow2", 64'(a_sel_err), 64'(0));
    a_reset = 1'b0; a_in_valid = 1'b0; a_err_clr = 1'b0;

    // N=3: legal load, then three illegal selects.
    b_step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("b_legal_data", b_out_data, 64'h2222_2222_2222_2222);
    check("b_legal_valid", 64'(b_out_valid), 64'(1));
    b_step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check("b_err_count_1", 64'(b_err_count), 64'(1));
    b_step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    b_step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check("b_sel_err", 64'(b_sel_err), 64'(1));
    check("b_err_count_3", 64'(b_err_count), 64'(3));
    check("b_illegal_data_kept", b_out_data, 64'h2222_2222_2222_2222);
    check("b_illegal_valid", 64'(b_out_valid), 64'(0));

    b_step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    check("b_clr_sel_err", 64'(b_sel_err), 64'(0));
    check("b_clr_err_count", 64'(b_err_count), 64'(0));

    b_step(1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
    check("b_clr_and_illegal_flag", 64'(b_sel_err), 64'(1));
    check("b_clr_and_illegal_count", 64'(b_err_count), 64'(1));

    // 260 more illegal accepts: count goes 1 -> 255 and stays there.
    for (int i = 0; i < 260; i++) begin
      b_step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      if (i == 252) check("b_count_254", 64'(b_err_count), 64'(254));
      if (i == 253) check("b_count_255", 64'(b_err_count), 64'(255));
    end
    check("b_count_saturated", 64'(b_err_count), 64'(255));

    b_step(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    check("b_flush_count_kept", 64'(b_err_count), 64'(255));
    check("b_flush_flag_kept", 64'(b_sel_err), 64'(1));

    b_step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    check("b_legal_after_sat", b_out_data, 64'h1111_1111_1111_1111);
    check("b_legal_after_sat_v", 64'(b_out_valid), 64'(1));

    b_reset = 1'b1;
    b_step(1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
    check("b_rst_data", b_out_data, 64'(0));
    check("b_rst_valid", 64'(b_out_valid), 64'(0));
    check("b_rst_sel_err", 64'(b_sel_err), 64'(0));
    check("b_rst_err_count", 64'(b_err_count), 64'(0));
    b_reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
